// File: rtl/player_trail_gen.sv
// player_trail_gen: per-frame ageing, left drift and cadence spawning of the player particle trail.
// Define TRAIL_JITTER_EN to add LFSR vertical jitter (clamped to the playfield) on spawned particles.
module player_trail_gen #(
  parameter int TRAIL_NUM   = 41,
  parameter int LIFE_MAX    = 10,
  parameter int SPAWN_DIV   = 2,
  parameter int DRIFT_STEP  = 4,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40,
  parameter int UPPER_BOUND = 20,
  parameter int LOWER_BOUND = 460
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic [1:0]                 gamemode,
  input  logic [8:0]                 player_y,
  output logic [TRAIL_NUM-1:0][9:0]  trail_x,
  output logic [TRAIL_NUM-1:0][8:0]  trail_y,
  output logic [TRAIL_NUM-1:0][3:0]  trail_life
);
  localparam int CW = SPAWN_DIV > 1 ? $clog2(SPAWN_DIV) : 1;
  logic [TRAIL_NUM-1:0][9:0] x_q, x_d, ax;
  logic [TRAIL_NUM-1:0][8:0] y_q, y_d;
  logic [TRAIL_NUM-1:0][3:0] life_q, life_d, al;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] sum;
  logic [8:0] cen, spawn_y;
  logic spawn;
  assign sum = {1'b0, player_y} + 10'(PLAYER_SIZE / 2);
  assign cen = sum[9] ? 9'd511 : sum[8:0];
`ifdef TRAIL_JITTER_EN
  localparam logic signed [11:0] YLO = 12'(UPPER_BOUND + 2);
  localparam logic signed [11:0] YHI = 12'(LOWER_BOUND - 3);
  logic [7:0] lfsr_q, lfsr_d;
  logic signed [11:0] j;
  assign j = $signed({3'b0, cen}) + $signed({9'b0, lfsr_q[2:0]}) - 12'sd3;
  assign spawn_y = 9'(j < YLO ? YLO : j > YHI ? YHI : j);
  assign lfsr_d = (frame_tick && gamemode[0]) ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 8'hA5;
    else lfsr_q <= lfsr_d;
`else
  assign spawn_y = cen;
`endif
  assign spawn = cnt_q == CW'(SPAWN_DIV - 1);
  // a live particle drifting past the left edge dies on the spot
  always_comb begin
    ax = x_q;
    al = life_q;
    for (int i = 0; i < TRAIL_NUM; i++) begin
      ax[i] = life_q[i] == 4'd0 ? x_q[i] : x_q[i] < 10'(DRIFT_STEP) ? 10'd0 : x_q[i] - 10'(DRIFT_STEP);
      al[i] = life_q[i] == 4'd0 || x_q[i] < 10'(DRIFT_STEP) ? 4'd0 : life_q[i] - 4'd1;
    end
  end
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    life_d = life_q;
    cnt_d = cnt_q;
    if (gamemode == 2'b00) begin
      x_d = '0;
      y_d = '0;
      life_d = '0;
      cnt_d = '0;
    end else if (frame_tick && gamemode[0]) begin
      if (gamemode == 2'b01 && spawn) begin
        x_d = {ax[TRAIL_NUM-2:0], 10'(PLAYER_X)};
        y_d = {y_q[TRAIL_NUM-2:0], spawn_y};
        life_d = {al[TRAIL_NUM-2:0], 4'(LIFE_MAX)};
        cnt_d = '0;
      end else begin
        x_d = ax;
        life_d = al;
        cnt_d = gamemode[1] ? cnt_q : cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      life_q <= '0;
      cnt_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      life_q <= life_d;
      cnt_q <= cnt_d;
    end
  assign trail_x = x_q;
  assign trail_y = y_q;
  assign trail_life = life_q;
endmodule
